// File: rtl/mmio_block_pkg.sv
// Shared register map for the MMIO block: window tag, register offsets
// measured downward from the top of the address space, and the decoder.
package mmio_block_pkg;

  localparam logic [1:0] IO_TAG = 2'b11;

  localparam int unsigned OFS_TIMER    = 4;
  localparam int unsigned OFS_EVENT    = 5;
  localparam int unsigned OFS_BUTTONS  = 6;
  localparam int unsigned OFS_MOUSE_X  = 7;
  localparam int unsigned OFS_MOUSE_Y  = 8;
  localparam int unsigned OFS_GPO_BASE = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TIMER,
    SEL_EVENT,
    SEL_BUTTONS,
    SEL_MOUSE_X,
    SEL_MOUSE_Y,
    SEL_GPO
  } reg_sel_e;

  // Maps an offset below TOP to the register it names.
  function automatic reg_sel_e decode_offset(input int unsigned ofs,
                                             input int unsigned num_gpo);
    if (ofs == OFS_TIMER)   return SEL_TIMER;
    if (ofs == OFS_EVENT)   return SEL_EVENT;
    if (ofs == OFS_BUTTONS) return SEL_BUTTONS;
    if (ofs == OFS_MOUSE_X) return SEL_MOUSE_X;
    if (ofs == OFS_MOUSE_Y) return SEL_MOUSE_Y;
    if (ofs >= OFS_GPO_BASE && ofs < OFS_GPO_BASE + num_gpo) return SEL_GPO;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mmio_block_read_port.sv
// One port's address decoder and registered read mux. The decode result is
// also handed back to the top so writes and read side effects use it.
module mmio_read_port
  import mmio_block_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int ADDRESS_SIZE = 12,
  parameter int NUM_GPO      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_SIZE-1:0]      address,
  input  logic [15:0]                  timer,
  input  logic [2:0]                   event_flags,
  input  logic [2:0]                   buttons,
  input  logic [15:0]                  mouse_x,
  input  logic [15:0]                  mouse_y_shadow,
  input  logic [NUM_GPO*DATA_SIZE-1:0] gpo,
  output reg_sel_e                     sel,
  output logic [2:0]                   gpo_idx,
  output logic [DATA_SIZE-1:0]         out
);

  logic [ADDRESS_SIZE-1:0] offset;
  logic                    in_window;
  logic [DATA_SIZE-1:0]    rdata;

  // TOP is all ones, so the distance below TOP is the bitwise inverse.
  assign offset    = ~address;
  assign in_window = (address[ADDRESS_SIZE-1 -: 2] == IO_TAG);
  assign sel       = in_window ? decode_offset(int'(offset), NUM_GPO) : SEL_NONE;
  // GPO offsets start at 16, so the low three offset bits are the index.
  assign gpo_idx   = offset[2:0];

  // Read mux; narrow registers are zero-extended to the data width.
  always_comb begin
    // NOTE: every path assigns rdata first, so no latch can be inferred.
    rdata = '0;
    case (sel)
      SEL_TIMER:   rdata[15:0] = timer;
      SEL_EVENT:   rdata[2:0]  = event_flags;
      SEL_BUTTONS: rdata[2:0]  = buttons;
      SEL_MOUSE_X: rdata[15:0] = mouse_x;
      SEL_MOUSE_Y: rdata[15:0] = mouse_y_shadow;
      SEL_GPO:     rdata       = gpo[int'(gpo_idx)*DATA_SIZE +: DATA_SIZE];
      default:     rdata       = '0;
    endcase
  end

  // Output register: unmapped window addresses read 0, outside addresses hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset)          out <= '0;
    else if (in_window) out <= rdata;
  end

endmodule

// File: rtl/mmio_block.sv
// Dual-port MMIO block: timer, mouse buttons with sticky edge events, a
// coherent mouse X/Y pair and writable GPO registers. Port a wins conflicts.
module mmio_block
  import mmio_block_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int ADDRESS_SIZE = 12,
  parameter int NUM_GPO      = 4,
  parameter int TICK_DIV     = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_SIZE-1:0]      a_address,
  input  logic [ADDRESS_SIZE-1:0]      b_address,
  input  logic [DATA_SIZE-1:0]         a_writeData,
  input  logic [DATA_SIZE-1:0]         b_writeData,
  input  logic                         a_we,
  input  logic                         b_we,
  input  logic                         a_re,
  input  logic                         b_re,
  input  logic                         lmb,
  input  logic                         mmb,
  input  logic                         rmb,
  input  logic [15:0]                  mouse_x,
  input  logic [15:0]                  mouse_y,
  output logic [DATA_SIZE-1:0]         a_out,
  output logic [DATA_SIZE-1:0]         b_out,
  output logic [NUM_GPO*DATA_SIZE-1:0] gpo
);

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [DATA_SIZE-1:0] gpo_q [NUM_GPO];
  logic [15:0]          timer_q;
  logic [PS_W-1:0]      prescaler_q;
  logic [2:0]           event_q;
  logic [15:0]          shadow_q;
  logic [2:0]           btn_meta, btn_sync, btn_prev;

  reg_sel_e   a_sel, b_sel;
  logic [2:0] a_gpo_idx, b_gpo_idx;

  logic a_wr_timer, b_wr_timer, event_clear, capture_y;

  for (genvar k = 0; k < NUM_GPO; k++) begin : g_gpo_flat
    assign gpo[k*DATA_SIZE +: DATA_SIZE] = gpo_q[k];
  end

  mmio_read_port #(
    .DATA_SIZE(DATA_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE), .NUM_GPO(NUM_GPO)
  ) u_port_a (
    .clk(clk), .reset(reset), .address(a_address), .timer(timer_q),
    .event_flags(event_q), .buttons(btn_sync), .mouse_x(mouse_x),
    .mouse_y_shadow(shadow_q), .gpo(gpo), .sel(a_sel), .gpo_idx(a_gpo_idx),
    .out(a_out)
  );

  mmio_read_port #(
    .DATA_SIZE(DATA_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE), .NUM_GPO(NUM_GPO)
  ) u_port_b (
    .clk(clk), .reset(reset), .address(b_address), .timer(timer_q),
    .event_flags(event_q), .buttons(btn_sync), .mouse_x(mouse_x),
    .mouse_y_shadow(shadow_q), .gpo(gpo), .sel(b_sel), .gpo_idx(b_gpo_idx),
    .out(b_out)
  );

  assign a_wr_timer  = a_we && (a_sel == SEL_TIMER);
  assign b_wr_timer  = b_we && (b_sel == SEL_TIMER);
  assign event_clear = (a_re && (a_sel == SEL_EVENT)) || (b_re && (b_sel == SEL_EVENT));
  assign capture_y   = (a_re && (a_sel == SEL_MOUSE_X)) || (b_re && (b_sel == SEL_MOUSE_X));

  // Button synchronizers and sticky rising-edge flags; an edge beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      event_q  <= '0;
    end else begin
      btn_meta <= {lmb, mmb, rmb};
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      event_q  <= (event_clear ? 3'b000 : event_q) | (btn_sync & ~btn_prev);
    end
  end

  // Prescaled timer; a write loads the value and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q     <= '0;
      prescaler_q <= '0;
    end else if (a_wr_timer) begin
      timer_q     <= a_writeData[15:0];
      prescaler_q <= '0;
    end else if (b_wr_timer) begin
      timer_q     <= b_writeData[15:0];
      prescaler_q <= '0;
    end else if (prescaler_q == PS_LAST) begin
      timer_q     <= timer_q + 16'd1;
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
    end
  end

  // MOUSE_Y shadow, captured by a qualified MOUSE_X read.
  always_ff @(posedge clk) begin
    if (reset)          shadow_q <= '0;
    else if (capture_y) shadow_q <= mouse_y;
  end

  // GPO registers; port a's write is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_GPO; k++) gpo_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_GPO; k++) begin
        // NOTE: when two non-blocking writes hit the same register, the later one takes effect.
        if (b_we && b_sel == SEL_GPO && b_gpo_idx == 3'(k)) gpo_q[k] <= b_writeData;
        if (a_we && a_sel == SEL_GPO && a_gpo_idx == 3'(k)) gpo_q[k] <= a_writeData;
      end
    end
  end

endmodule

// File: tb/tb_mmio_block.sv
// Scoreboard bench for mmio_block: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares them.
module tb_mmio_block;

  localparam int TICK_DIV = 4;
  localparam int NUM_GPO  = 4;

  logic        clk, reset;
  logic [11:0] a_address, b_address;
  logic [15:0] a_writeData, b_writeData;
  logic        a_we, b_we, a_re, b_re, lmb, mmb, rmb;
  logic [15:0] mouse_x, mouse_y;
  logic [15:0] a_out, b_out;
  logic [63:0] gpo;

  mmio_block #(
    .DATA_SIZE(16), .ADDRESS_SIZE(12), .NUM_GPO(NUM_GPO), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .b_address(b_address),
    .a_writeData(a_writeData), .b_writeData(b_writeData),
    .a_we(a_we), .b_we(b_we), .a_re(a_re), .b_re(b_re),
    .lmb(lmb), .mmb(mmb), .rmb(rmb),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .a_out(a_out), .b_out(b_out), .gpo(gpo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [63:0] g;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  int unsigned timer_base, timer_since;  // timer = base + elapsed edges / TICK_DIV
  logic [15:0] m_gpo [NUM_GPO];
  logic [2:0]  m_flags;
  logic [15:0] m_shadow, m_a_out, m_b_out;
  logic [2:0]  btn_hist[$];              // button levels at the last edges, newest first
  logic [2:0]  cur_btn;
  logic [15:0] cur_mx, cur_my;

  function automatic bit in_win(input logic [11:0] a);
    return a[11:10] == 2'b11;
  endfunction

  function automatic int ofs_of(input logic [11:0] a);
    return in_win(a) ? 4095 - int'(a) : -1;
  endfunction

  function automatic logic [15:0] model_read(input logic [11:0] a);
    int o;
    o = ofs_of(a);
    if (o == 4) return 16'((timer_base + timer_since / TICK_DIV) % 65536);
    if (o == 5) return {13'd0, m_flags};
    if (o == 6) return {13'd0, btn_hist[1]};  // input level two edges ago
    if (o == 7) return cur_mx;
    if (o == 8) return m_shadow;
    if (o >= 16 && o < 16 + NUM_GPO) return m_gpo[o-16];
    return 16'h0000;
  endfunction

  task automatic do_cycle(input logic rst,
                          input logic [11:0] aa, input logic [15:0] ad, input logic awe, input logic are,
                          input logic [11:0] ba, input logic [15:0] bd, input logic bwe, input logic bre);
    exp_t        e;
    logic [15:0] ra, rb;
    logic [2:0]  rises;
    reset = rst;
    a_address = aa; a_writeData = ad; a_we = awe; a_re = are;
    b_address = ba; b_writeData = bd; b_we = bwe; b_re = bre;
    {lmb, mmb, rmb} = cur_btn;
    mouse_x = cur_mx; mouse_y = cur_my;
    if (rst) begin
      timer_base = 0; timer_since = 0;
      for (int k = 0; k < NUM_GPO; k++) m_gpo[k] = '0;
      m_flags = '0; m_shadow = '0; m_a_out = '0; m_b_out = '0;
      btn_hist = '{3'b000, 3'b000, 3'b000};
    end else begin
      ra = model_read(aa);
      rb = model_read(ba);
      if (in_win(aa)) m_a_out = ra;
      if (in_win(ba)) m_b_out = rb;
      rises = btn_hist[1] & ~btn_hist[2];
      if ((are && ofs_of(aa) == 5) || (bre && ofs_of(ba) == 5)) m_flags = 3'b000;
      m_flags = m_flags | rises;
      if ((are && ofs_of(aa) == 7) || (bre && ofs_of(ba) == 7)) m_shadow = cur_my;
      if (awe && ofs_of(aa) == 4) begin
        timer_base = ad; timer_since = 0;
      end else if (bwe && ofs_of(ba) == 4) begin
        timer_base = bd; timer_since = 0;
      end else begin
        timer_since++;
      end
      if (bwe && ofs_of(ba) >= 16 && ofs_of(ba) < 16 + NUM_GPO) m_gpo[ofs_of(ba)-16] = bd;
      if (awe && ofs_of(aa) >= 16 && ofs_of(aa) < 16 + NUM_GPO) m_gpo[ofs_of(aa)-16] = ad;
      btn_hist.push_front(cur_btn);
      void'(btn_hist.pop_back());
    end
    e.cyc = cyc + 1;
    e.a   = m_a_out;
    e.b   = m_b_out;
    e.g   = {m_gpo[3], m_gpo[2], m_gpo[1], m_gpo[0]};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic rd_a(input logic [11:0] aa);
    do_cycle(1'b0, aa, 16'h0, 1'b0, 1'b1, 12'h000, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_a(input logic [11:0] aa, input logic [15:0] d);
    do_cycle(1'b0, aa, d, 1'b1, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every registered output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("sb_a_out", 64'(a_out), 64'(e.a));
        check("sb_b_out", 64'(b_out), 64'(e.b));
        check("sb_gpo", gpo, e.g);
      end
    end
  end

  logic [11:0] addr_pool [14] = '{12'hFFB, 12'hFFA, 12'hFF9, 12'hFF8, 12'hFF7,
                                  12'hFEF, 12'hFEE, 12'hFED, 12'hFEC, 12'hFEB,
                                  12'hFFF, 12'hC00, 12'h100, 12'h7FF};

  initial begin
    logic [15:0] g0;
    logic [11:0] ra_addr, rb_addr;
    cur_btn = 3'b000; cur_mx = 16'd0; cur_my = 16'd0;
    reset = 1'b1;
    a_address = '0; b_address = '0; a_writeData = '0; b_writeData = '0;
    a_we = 0; b_we = 0; a_re = 0; b_re = 0; lmb = 0; mmb = 0; rmb = 0;
    mouse_x = '0; mouse_y = '0;
    @(posedge clk);
    #1;

    // Reset state.
    do_cycle(1'b1, 12'hFEF, 16'hFFFF, 1'b1, 1'b1, 12'hFFB, 16'h5555, 1'b1, 1'b1);
    do_cycle(1'b1, 12'h000, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0);
    check("rst_a_out", 64'(a_out), 64'h0);
    check("rst_b_out", 64'(b_out), 64'h0);
    rd_a(12'hFF9); check("rst_buttons", 64'(a_out), 64'h0);
    rd_a(12'hFF8); check("rst_mouse_x", 64'(a_out), 64'h0);
    rd_a(12'hFEF); check("rst_gpo0_rd", 64'(a_out), 64'h0);
    check("rst_gpo", gpo, 64'h0);

    // lmb pulse sets EVENT bit 2; a read clears it.
    cur_btn = 3'b100; idle(5); cur_btn = 3'b000;
    rd_a(12'hFFA); check("event_lmb", 64'(a_out), 64'h4);
    rd_a(12'hFFA); check("event_cleared", 64'(a_out), 64'h0);

    // rmb edge coincides with a clearing read: old value returned, flag survives.
    cur_btn = 3'b001; idle(2);
    rd_a(12'hFFA); check("event_race_old", 64'(a_out), 64'h0);
    rd_a(12'hFFA); check("event_race_kept", 64'(a_out), 64'h1);
    cur_btn = 3'b000;

    // Timer wrap and write-over-tick.
    wr_a(12'hFFB, 16'hFFFE); idle(8);
    rd_a(12'hFFB); check("timer_wrap", 64'(a_out), 64'h0000);
    idle(2);
    wr_a(12'hFFB, 16'h0010);
    rd_a(12'hFFB); check("timer_write_beats_tick", 64'(a_out), 64'h0010);

    // Port a wins GPO collision; RO write ignored; outside address holds a_out.
    do_cycle(1'b0, 12'hFEF, 16'h1234, 1'b1, 1'b0, 12'hFEF, 16'hABCD, 1'b1, 1'b0);
    g0 = gpo[15:0];
    check("gpo_port_a_wins", 64'(g0), 64'h1234);
    wr_a(12'hFF9, 16'hFFFF);
    rd_a(12'hFF9); check("ro_write_ignored", 64'(a_out), 64'h0);
    rd_a(12'hFEF); check("gpo0_read", 64'(a_out), 64'h1234);
    rd_a(12'h100); check("outside_holds", 64'(a_out), 64'h1234);

    // Coherent mouse pair, and shadow reset.
    cur_mx = 16'd10; cur_my = 16'd20;
    rd_a(12'hFF8); check("mouse_x", 64'(a_out), 64'd10);
    cur_my = 16'd99;
    rd_a(12'hFF7); check("mouse_y_shadow", 64'(a_out), 64'd20);
    rd_a(12'hFF8);
    do_cycle(1'b1, 12'h000, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0);
    rd_a(12'hFF7); check("shadow_after_reset", 64'(a_out), 64'h0);

    // Randomized traffic on both ports.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) cur_btn = 3'($urandom);
      cur_mx = 16'($urandom);
      cur_my = 16'($urandom);
      ra_addr = addr_pool[$urandom_range(0, 13)];
      rb_addr = addr_pool[$urandom_range(0, 13)];
      do_cycle($urandom_range(0, 99) == 0,
               ra_addr, 16'($urandom), 1'($urandom), 1'($urandom),
               rb_addr, 16'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_block.md
MMIO_BLOCK -- requirements
Module: mmio_block

Interface
REQ-001 Parameter DATA_SIZE, default 16, data word width (minimum 16).
REQ-002 Parameter ADDRESS_SIZE, default 12, address width; the IO window is the top quarter of the space (address top two bits == 2'b11).
REQ-003 Parameter NUM_GPO, default 4, range 1..8, number of writable general-purpose output registers.
REQ-004 Parameter TICK_DIV, default 50000, clk cycles per timer tick (minimum 1).
REQ-005 Port list, in order:
- clk, input, 1: the one clock.
- reset, input, 1: reset, synchronous, active-high.
- a_address, b_address, input, ADDRESS_SIZE each: port addresses.
- a_writeData, b_writeData, input, DATA_SIZE each: write data.
- a_we, b_we, input, 1 each: write strobes.
- a_re, b_re, input, 1 each: read strobes; qualify read side effects.
- lmb, mmb, rmb, input, 1 each: asynchronous mouse buttons.
- mouse_x, mouse_y, input, 16 each: mouse position.
- a_out, b_out, output, DATA_SIZE each: registered read data.
- gpo, output, NUM_GPO*DATA_SIZE: GPO register k at bits [k*DATA_SIZE +: DATA_SIZE].

Function
REQ-006 TOP = 2^ADDRESS_SIZE-1. Register map: TOP-4 TIMER (R/W), TOP-5 EVENT (R, clear-on-read), TOP-6 BUTTONS (R), TOP-7 MOUSE_X (R), TOP-8 MOUSE_Y (R), TOP-16-k GPO k (R/W, k<NUM_GPO). For ADDRESS_SIZE=12: FFB, FFA, FF9, FF8, FF7, FEF downward.
REQ-007 Reads: 1-cycle latency; out is registered at the clk edge after the address is presented, with the upper bits zero-extended.
REQ-008 Address inside the IO window but unmapped: out <= 0 and writes are ignored. Address outside the IO window: out holds its previous value and there are no side effects.
REQ-009 lmb/mmb/rmb each pass through a 2-flop synchronizer. BUTTONS = {0…, lmb_s, mmb_s, rmb_s}, with lmb_s at bit 2.
REQ-010 EVENT bits [2:0] are sticky flags set on a synchronized rising edge of lmb/mmb/rmb. A qualified read (re=1, address=EVENT) returns the current flags and clears them on the same edge.
REQ-011 If a rising edge and a clearing read occur on the same cycle, the read returns the old value and the flag for that edge stays set after the read.
REQ-012 A qualified read of MOUSE_X captures mouse_y into a shadow register. MOUSE_Y reads return the shadow, so an X-then-Y read pair is coherent. The shadow resets to 0.
REQ-013 Prescaler counts 0..TICK_DIV-1 and wraps. TIMER (16-bit) increments by 1 on each wrap, modulo 2^16 (FFFF→0000).
REQ-014 A write to TIMER loads writeData[15:0] into TIMER and zeroes the prescaler. This write overrides an increment on the same cycle.
REQ-015 A write to GPO k updates it on the clk edge; reads on the same edge return the old value.
REQ-016 Writes to read-only registers are ignored.
REQ-017 If both ports write the same register on the same cycle, port a wins.
REQ-018 If both ports perform a clearing read of EVENT on the same cycle, both return the same pre-clear value.

Reset
REQ-019 While reset is high at a clk edge, the following reset to 0: a_out, b_out, all GPO registers, TIMER, prescaler, EVENT flags, the MOUSE_Y shadow and the synchronizer flops.
REQ-020 Reset takes priority over every concurrent write, read side effect or tick. Operations in flight on the reset cycle are discarded.
REQ-021 During the first cycle after reset deasserts, EVENT flags do not set from synchronizers that are still filling.

Structure
REQ-022 A shared package holds: register-offset constants (OFS_TIMER=4, OFS_EVENT=5, OFS_BUTTONS=6, OFS_MOUSE_X=7, OFS_MOUSE_Y=8, OFS_GPO_BASE=16) and the IO-window tag 2'b11.
REQ-023 The per-port read path is one sub-module, mmio_read_port, instantiated twice (a and b). State (GPO, TIMER, EVENT, shadow) lives once in the top module.

Verification
REQ-024 Reset, then read FF9, FF8, FEF with re=1 → each returns 0 one cycle later; gpo==0.
REQ-025 Pulse lmb high for 5 cycles, then read FFA on port a → 0x0004; a second read → 0x0000.
REQ-026 Rising edge on rmb synchronized on the same cycle as a clearing read of FFA → read returns 0; the next read returns 0x0001.
REQ-027 With TICK_DIV=4, write TIMER=FFFE, wait 8 cycles → reads 0000. Write TIMER=0x0010 on the same cycle as a tick → 0x0010.
REQ-028 Port a writes FEF=0x1234 while port b writes FEF=0xABCD on the same cycle → gpo[15:0]==0x1234. A write to FF9 is ignored. Address 0x100 leaves a_out unchanged.
REQ-029 mouse_x=10, mouse_y=20; read FF8; set mouse_y=99; read FF7 → 10 then 20. Assert reset mid-sequence → the shadow reads 0.
